mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one unified memory port between the pipeline's instruction-fetch interface and its data-memory interface. Sits between the `cpu` top level (`imem_*` / `dmem_*` ports) and a single-ported memory or cache. Grants one requester at a time, registers the granted request, and issues it downstream as a one-cycle command. Returns the response only to the granted requester. Data has fixed priority over fetch, with a starvation guard for fetch.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced (legal range 1–15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising edge).
- imem_addr  in  32  fetch address.
- imem_rmask  in  4  fetch read mask; nonzero means a fetch request is present.
- imem_rdata  out  32  fetch read data; valid only when imem_resp==1.
- imem_resp  out  1  fetch completion, one cycle.
- dmem_addr  in  32  data address.
- dmem_rmask  in  4  data read mask.
- dmem_wmask  in  4  data write mask.
- dmem_wdata  in  32  data write data.
- dmem_rdata  out  32  data read data; valid only when dmem_resp==1.
- dmem_resp  out  1  data completion, one cycle.
- mem_addr  out  32  downstream address.
- mem_rmask  out  4  downstream read mask.
- mem_wmask  out  4  downstream write mask.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data.
- mem_resp  in  1  downstream completion, one cycle.

## Operation

Request presence:
- Fetch request: imem_rmask != 0.
- Data request: (dmem_rmask | dmem_wmask) != 0.

Requester rules:
- A requester holds all of its request signals stable from assertion through its resp cycle.
- In the cycle after resp, it presents either a new request or no request.

Data requests with both masks nonzero:
- Treated as writes.
- The issued mem_rmask is 0.

States:
- IDLE
  - No request: stay in IDLE.
  - Only a data request: go to ISSUE_D.
  - Only a fetch request: go to ISSUE_I.
  - Both requests: go to ISSUE_I if starve_cnt == STARVE_LIMIT, otherwise ISSUE_D.
  - On the IDLE→ISSUE_x edge, register the winner's addr, masks and wdata into the command register.
- ISSUE_I / ISSUE_D
  - Drive mem_* from the command register for exactly this one cycle.
  - Go to WAIT_I / WAIT_D.
  - If mem_resp==1 in this cycle, complete the request immediately, exactly as in WAIT.
- WAIT_I / WAIT_D
  - mem_rmask = 0 and mem_wmask = 0; mem_addr and mem_wdata hold the registered values.
  - Stay until mem_resp==1.
  - On mem_resp==1: pulse the matching `*_resp` for this same cycle and go to IDLE.
  - `*_rdata` = mem_rdata combinationally during that cycle.

Starvation counter (starve_cnt):
- Width is 4 bits.
- Updated on the IDLE→ISSUE edge only:
  - Data granted while a fetch request is present: increment, saturating at STARVE_LIMIT.
  - Fetch granted: clear to 0.
  - Data granted with no fetch request present: clear to 0.

Response routing:
- imem_resp and dmem_resp are never 1 in the same cycle.
- Both resp outputs are 0 in IDLE.
- A mem_resp arriving in IDLE is ignored and is not forwarded.
- imem_rdata and dmem_rdata are driven as 0 whenever their resp is 0.

Reset:
- State → IDLE, starve_cnt → 0, command register → 0.
- Reset during WAIT abandons the outstanding request; its late mem_resp falls in IDLE and is dropped.

## Timing

Reset values:
- All outputs are 0.
- mem_addr, mem_wdata, mem_rmask and mem_wmask are 0 from the cycle after reset until the first issue.

Latency:
- Request first seen in IDLE at cycle N.
- Downstream command at cycle N+1.
- Earliest resp at N+1 (zero-wait memory).
- Arbiter adds one cycle over a direct connection.
- Back-to-back throughput with zero-wait memory is one access per 2 cycles. The resp cycle returns to IDLE, and the next request is seen at cycle N+2.

Command signals:
- mem_rmask and mem_wmask are nonzero for exactly one cycle per access, never otherwise.

Stability:
- No combinational path from imem_* or dmem_* request inputs to mem_* outputs.
- Only mem_rdata → `*_rdata` and mem_resp → `*_resp` are combinational.

Simultaneous events:
- A new request arriving in the same cycle as mem_resp is not sampled. It is sampled in the following IDLE cycle.

## Test plan

- Reset, then one fetch (addr 0x6000_0000, rmask 0xF), memory with 3-cycle wait:
  - mem_addr = 0x6000_0000 and mem_rmask = 0xF for one cycle only.
  - imem_resp one cycle, 4 cycles after issue.
  - imem_rdata equals mem_rdata.
  - dmem_resp stays 0.
- Fetch and data store (addr 0x100, wmask 0x3, wdata 0xDEAD_BEEF) asserted together, STARVE_LIMIT=4:
  - Data issued first with mem_rmask = 0.
  - Fetch issued after dmem_resp.
- Fetch held continuously plus 5 back-to-back data reads, STARVE_LIMIT=4:
  - Grant order D,D,D,D,I,D.
  - starve_cnt returns to 0 after the fetch grant.
- Data request with rmask=0xF and wmask=0xF:
  - Issued as mem_wmask=0xF, mem_rmask=0.
- rst driven low during WAIT_D, then mem_resp pulsed two cycles later:
  - No dmem_resp or imem_resp.
  - Arbiter is in IDLE.
  - Next fetch is served normally.
- Zero-wait memory (mem_resp in the issue cycle) with continuous fetches:
  - One imem_resp every 2 cycles.
  - mem_rmask never nonzero on two consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester and shared memory port signals for mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
               mem_rdata, mem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
               mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data: one registered command cycle after the grant, responses routed back combinationally.
// Requesters hold their request until their resp. The memory stalls the access by delaying mem_resp.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_cnt_nxt;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_rmask, cmd_wmask;
    logic        fetch_req, data_req;
    logic        grant_i, grant_d;

    assign fetch_req = |bus.imem_rmask;
    assign data_req  = |(bus.dmem_rmask | bus.dmem_wmask);

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        grant_i        = 1'b0;
        grant_d        = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has already lost LIMIT arbitrations in a row.
                if (fetch_req && (!data_req || starve_cnt == LIMIT)) begin
                    grant_i        = 1'b1;
                    state_nxt      = ISSUE_I;
                    starve_cnt_nxt = 4'd0;
                end else if (data_req) begin
                    grant_d   = 1'b1;
                    state_nxt = ISSUE_D;
                    if (!fetch_req)
                        starve_cnt_nxt = 4'd0;
                    else if (starve_cnt < LIMIT)
                        starve_cnt_nxt = starve_cnt + 4'd1;
                end
            end
            ISSUE_I, WAIT_I: state_nxt = bus.mem_resp ? IDLE : WAIT_I;
            ISSUE_D, WAIT_D: state_nxt = bus.mem_resp ? IDLE : WAIT_D;
            default:         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr   = cmd_addr;
        bus.mem_wdata  = cmd_wdata;
        bus.mem_rmask  = 4'h0;
        bus.mem_wmask  = 4'h0;
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        if (state == ISSUE_I || state == ISSUE_D) begin
            bus.mem_rmask = cmd_rmask;
            bus.mem_wmask = cmd_wmask;
        end
        if ((state == ISSUE_I || state == WAIT_I) && bus.mem_resp) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = bus.mem_rdata;
        end
        if ((state == ISSUE_D || state == WAIT_D) && bus.mem_resp) begin
            bus.dmem_resp  = 1'b1;
            bus.dmem_rdata = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            cmd_addr   <= 32'h0;
            cmd_rmask  <= 4'h0;
            cmd_wmask  <= 4'h0;
            cmd_wdata  <= 32'h0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            if (grant_i) begin
                cmd_addr  <= bus.imem_addr;
                cmd_rmask <= bus.imem_rmask;
                cmd_wmask <= 4'h0;
                cmd_wdata <= 32'h0;
            end else if (grant_d) begin
                // A data access carrying both masks is a write.
                cmd_addr  <= bus.dmem_addr;
                cmd_rmask <= (|bus.dmem_wmask) ? 4'h0 : bus.dmem_rmask;
                cmd_wmask <= bus.dmem_wmask;
                cmd_wdata <= bus.dmem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level arbitration model.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: the access currently owning the port, if any.
    bit          m_busy  = 0;
    bit          m_fetch = 0;
    bit          m_fresh = 0;
    logic [31:0] m_addr  = 32'h0;
    logic [3:0]  m_rmask = 4'h0;
    logic [3:0]  m_wmask = 4'h0;
    logic [31:0] m_wdata = 32'h0;
    int          m_lost  = 0;
    string       m_grants = "";

    // Observations of the DUT's downstream port.
    string       d_grants = "";
    int          n_issue = 0, n_iresp = 0, n_dresp = 0, n_b2b = 0;
    int          last_issue_cyc = 0, last_iresp_cyc = 0, prev_iresp_cyc = 0;
    logic [31:0] last_issue_addr = 32'h0, last_issue_wdata = 32'h0;
    logic [3:0]  last_issue_rmask = 4'h0, last_issue_wmask = 4'h0;
    bit          cmd_prev = 0, gap_on = 0;
    bit          i_resp_seen = 0, d_resp_seen = 0;

    logic        e_ir, e_dr, f_req, d_req, cmd_now;
    logic [3:0]  e_rm, e_wm;

    // Memory responder controls.
    int          mem_wait = -1;
    bit          mem_manual = 1;
    bit          man_resp = 0;
    int          mem_cnt = 0;

    // Random requester agents.
    bit          i_active = 0, d_active = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: check every cycle at the falling edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            e_ir = m_busy && m_fetch && (bus.mem_resp === 1'b1);
            e_dr = m_busy && !m_fetch && (bus.mem_resp === 1'b1);
            e_rm = m_fresh ? m_rmask : 4'h0;
            e_wm = m_fresh ? m_wmask : 4'h0;
            chk("mem_addr",   bus.mem_addr,  m_addr);
            chk("mem_wdata",  bus.mem_wdata, m_wdata);
            chk("mem_rmask",  32'(bus.mem_rmask), 32'(e_rm));
            chk("mem_wmask",  32'(bus.mem_wmask), 32'(e_wm));
            chk("imem_resp",  32'(bus.imem_resp), 32'(e_ir));
            chk("dmem_resp",  32'(bus.dmem_resp), 32'(e_dr));
            chk("imem_rdata", bus.imem_rdata, e_ir ? bus.mem_rdata : 32'h0);
            chk("dmem_rdata", bus.dmem_rdata, e_dr ? bus.mem_rdata : 32'h0);

            cmd_now = (bus.mem_rmask != 4'h0) || (bus.mem_wmask != 4'h0);
            if (cmd_now) begin
                n_issue++;
                last_issue_cyc   = cyc;
                last_issue_addr  = bus.mem_addr;
                last_issue_rmask = bus.mem_rmask;
                last_issue_wmask = bus.mem_wmask;
                last_issue_wdata = bus.mem_wdata;
                if (bus.mem_addr[31:28] == 4'h6) d_grants = {d_grants, "I"};
                else                             d_grants = {d_grants, "D"};
            end
            if (cmd_now && cmd_prev) n_b2b++;
            cmd_prev = cmd_now;
            if (bus.imem_resp === 1'b1) begin
                n_iresp++;
                last_iresp_cyc = cyc;
                if (gap_on && prev_iresp_cyc > 0)
                    chk("zw_resp_gap", 32'(cyc - prev_iresp_cyc), 32'd2);
                prev_iresp_cyc = cyc;
            end
            if (bus.dmem_resp === 1'b1) n_dresp++;
            i_resp_seen = (bus.imem_resp === 1'b1);
            d_resp_seen = (bus.dmem_resp === 1'b1);

            if (rst == 1'b0) begin
                m_busy = 0; m_fresh = 0; m_lost = 0;
                m_addr = 32'h0; m_rmask = 4'h0; m_wmask = 4'h0; m_wdata = 32'h0;
            end else if (m_busy) begin
                m_fresh = 0;
                if (bus.mem_resp === 1'b1) m_busy = 0;
            end else begin
                f_req = bus.imem_rmask != 4'h0;
                d_req = (bus.dmem_rmask | bus.dmem_wmask) != 4'h0;
                if (f_req && (!d_req || m_lost >= LIMIT)) begin
                    m_fetch = 1; m_busy = 1; m_fresh = 1; m_lost = 0;
                    m_addr = bus.imem_addr; m_rmask = bus.imem_rmask;
                    m_wmask = 4'h0; m_wdata = 32'h0;
                    m_grants = {m_grants, "I"};
                end else if (d_req) begin
                    m_fetch = 0; m_busy = 1; m_fresh = 1;
                    m_addr = bus.dmem_addr; m_wmask = bus.dmem_wmask; m_wdata = bus.dmem_wdata;
                    m_rmask = (bus.dmem_wmask != 4'h0) ? 4'h0 : bus.dmem_rmask;
                    m_lost = f_req ? ((m_lost < LIMIT) ? m_lost + 1 : LIMIT) : 0;
                    m_grants = {m_grants, "D"};
                end
            end
        end
    end

    // Memory responder: mem_resp arrives mem_wait cycles after the command cycle (random 0..3 if negative).
    initial begin
        bus.mem_rdata = 32'h0;
        bus.mem_resp  = 1'b0;
        forever begin
            tick();
            bus.mem_rdata = $urandom;
            if (mem_manual) begin
                bus.mem_resp = man_resp;
            end else if (bus.mem_rmask != 4'h0 || bus.mem_wmask != 4'h0) begin
                mem_cnt = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
                bus.mem_resp = (mem_cnt == 0);
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                bus.mem_resp = (mem_cnt == 0);
            end else begin
                bus.mem_resp = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic set_f(input logic [31:0] addr, input logic [3:0] rmask);
        bus.imem_addr  = addr;
        bus.imem_rmask = rmask;
    endtask

    task automatic set_d(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        bus.dmem_addr  = addr;
        bus.dmem_rmask = rm;
        bus.dmem_wmask = wm;
        bus.dmem_wdata = wd;
    endtask

    task automatic agents_step(input int p_new);
        int kind;
        if (i_active && i_resp_seen) i_active = 0;
        if (d_active && d_resp_seen) d_active = 0;
        if (!i_active && int'($urandom_range(0, 99)) < p_new) begin
            i_active = 1;
            set_f(32'h6000_0000 | ($urandom & 32'h0fff_fffc), 4'($urandom_range(1, 15)));
        end else if (!i_active) begin
            set_f($urandom, 4'h0);
        end
        if (!d_active && int'($urandom_range(0, 99)) < p_new) begin
            d_active = 1;
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       set_d($urandom & 32'h0000_0ffc, 4'($urandom_range(1, 15)), 4'h0, $urandom);
                1:       set_d($urandom & 32'h0000_0ffc, 4'h0, 4'($urandom_range(1, 15)), $urandom);
                default: set_d($urandom & 32'h0000_0ffc, 4'($urandom_range(1, 15)),
                               4'($urandom_range(1, 15)), $urandom);
            endcase
        end else if (!d_active) begin
            set_d($urandom, 4'h0, 4'h0, $urandom);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((i_active || d_active) && k < 100) begin
            tick();
            agents_step(0);
            k++;
        end
        chk("drain_idle", 32'(i_active || d_active), 32'd0);
        set_f(32'h0, 4'h0);
        set_d(32'h0, 4'h0, 4'h0, 32'h0);
        repeat (2) tick();
    endtask

    task automatic wait_resp(input bit want_i, input string name);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(want_i ? i_resp_seen : d_resp_seen) && k < 50);
        chk(name, 32'(want_i ? i_resp_seen : d_resp_seen), 32'd1);
    endtask

    initial begin
        int nd, k, v, base_i, base_d;
        bit f_on;
        set_f(32'h0, 4'h0);
        set_d(32'h0, 4'h0, 4'h0, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_rmask", 32'(bus.mem_rmask), 32'h0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_imem_resp", 32'(bus.imem_resp), 32'h0);
        chk("rst_dmem_resp", 32'(bus.dmem_resp), 32'h0);

        // Randomized traffic with random memory latency.
        mem_manual = 0;
        mem_wait   = -1;
        for (int i = 0; i < 1500; i++) begin tick(); agents_step(30); end
        for (int i = 0; i < 1500; i++) begin tick(); agents_step(95); end
        drain();
        chk("no_b2b_cmd_random", 32'(n_b2b), 32'd0);

        // Single fetch, resp four cycles after the command.
        mem_wait = 4;
        base_d = n_dresp;
        set_f(32'h6000_0000, 4'hF);
        wait_resp(1, "t1_fetch_done");
        set_f(32'h0, 4'h0);
        chk("t1_issue_addr",  last_issue_addr, 32'h6000_0000);
        chk("t1_issue_rmask", 32'(last_issue_rmask), 32'hF);
        chk("t1_resp_delay",  32'(last_iresp_cyc - last_issue_cyc), 32'd4);
        chk("t1_no_dmem_resp", 32'(n_dresp - base_d), 32'd0);
        repeat (2) tick();

        // Fetch and store together: data first, fetch after dmem_resp.
        mem_wait = 1;
        d_grants = "";
        set_f(32'h6000_0010, 4'hF);
        set_d(32'h0000_0100, 4'h0, 4'h3, 32'hDEAD_BEEF);
        wait_resp(0, "t2_data_done");
        set_d(32'h0, 4'h0, 4'h0, 32'h0);
        chk("t2_data_addr",  last_issue_addr, 32'h0000_0100);
        chk("t2_data_rmask", 32'(last_issue_rmask), 32'h0);
        chk("t2_data_wmask", 32'(last_issue_wmask), 32'h3);
        chk("t2_data_wdata", last_issue_wdata, 32'hDEAD_BEEF);
        wait_resp(1, "t2_fetch_done");
        set_f(32'h0, 4'h0);
        chk_s("t2_order", d_grants, "DI");
        repeat (2) tick();

        // Fetch held against five back-to-back data reads.
        d_grants = "";
        m_grants = "";
        nd = 0;
        f_on = 1;
        set_f(32'h6000_0040, 4'hF);
        set_d(32'h0000_0400, 4'hF, 4'h0, 32'h0);
        k = 0;
        while ((nd < 5 || f_on) && k < 200) begin
            tick();
            k++;
            if (d_resp_seen) begin
                nd++;
                if (nd < 5) set_d(32'h0000_0400 + 32'(4 * nd), 4'hF, 4'h0, 32'h0);
                else        set_d(32'h0, 4'h0, 4'h0, 32'h0);
            end
            if (i_resp_seen) begin
                f_on = 0;
                set_f(32'h0, 4'h0);
            end
        end
        chk_s("t3_dut_order", d_grants, "DDDDID");
        chk_s("t3_model_order", m_grants, "DDDDID");
        chk("t3_model_starve_clear", 32'(m_lost), 32'd0);
        repeat (2) tick();

        // Data access with both masks is issued as a write.
        mem_wait = 2;
        set_d(32'h0000_0200, 4'hF, 4'hF, 32'h1234_5678);
        wait_resp(0, "t4_done");
        set_d(32'h0, 4'h0, 4'h0, 32'h0);
        chk("t4_rmask", 32'(last_issue_rmask), 32'h0);
        chk("t4_wmask", 32'(last_issue_wmask), 32'hF);
        repeat (2) tick();

        // Reset while waiting on a data access; the late mem_resp must be dropped.
        mem_manual = 1;
        man_resp = 0;
        base_i = n_iresp;
        base_d = n_dresp;
        set_d(32'h0000_0300, 4'hF, 4'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        set_d(32'h0, 4'h0, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        man_resp = 1;
        tick();
        man_resp = 0;
        chk("t5_no_dmem_resp", 32'(n_dresp - base_d), 32'd0);
        chk("t5_no_imem_resp", 32'(n_iresp - base_i), 32'd0);
        mem_manual = 0;
        mem_wait = 1;
        tick();
        v = cyc;
        set_f(32'h6000_0080, 4'h7);
        wait_resp(1, "t5_fetch_done");
        set_f(32'h0, 4'h0);
        chk("t5_fetch_latency", 32'(last_issue_cyc - v), 32'd2);
        chk("t5_fetch_addr", last_issue_addr, 32'h6000_0080);
        repeat (2) tick();

        // Zero-wait memory with continuous fetches.
        mem_wait = 0;
        base_i = n_iresp;
        prev_iresp_cyc = 0;
        gap_on = 1;
        v = 0;
        set_f(32'h6000_0100, 4'hF);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i_resp_seen) begin
                v++;
                set_f(32'h6000_0100 + 32'(4 * v), 4'hF);
            end
        end
        set_f(32'h0, 4'h0);
        repeat (3) tick();
        gap_on = 0;
        chk("t6_resp_count", 32'(n_iresp - base_i >= 19 && n_iresp - base_i <= 21), 32'd1);
        chk("no_b2b_cmd_total", 32'(n_b2b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
